// File: rtl/prbs_checker_if.sv
// prbs_checker_if: receive-side bit stream and status bundle for prbs_checker.
//   master : drives bit_in, bit_valid, restart, err_clear; observes status
//   slave  : the checker; samples the stream, drives locked, err_pulse, err_count
interface prbs_checker_if #(
  parameter int ERR_WIDTH = 8
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 restart;
  logic                 err_clear;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (
    output bit_in, bit_valid, restart, err_clear,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  bit_in, bit_valid, restart, err_clear,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the XNOR Fibonacci lfsr stream.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - prbs_checker_if.slave: bit_in/bit_valid stream, restart and
//            err_clear controls in; locked, err_pulse, err_count out (registered)
//
// state  | meaning
// SEED   | loading the shadow register straight from the stream
// HUNT   | shadow follows the stream, counting consecutive predictions that hold
// LOCKED | shadow free-runs on its own prediction, mismatches are counted errors
module prbs_checker #(
  parameter int NUM_BITS    = 8,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_WIDTH   = 8
) (
  input logic           clk,
  input logic           rst_n,
  prbs_checker_if.slave bus
);

  localparam int FW = $clog2(NUM_BITS + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(NUM_BITS - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_ERRS - 1);

  localparam logic [NUM_BITS:1] C_RST = NUM_BITS'({(NUM_BITS/2){2'b01}});

  // Same tap table as the lfsr generator; bit k of the mask selects c[k].
  function automatic logic [NUM_BITS:1] tap_mask();
    int t0, t1, t2, t3;
    logic [NUM_BITS:1] m;
    t0 = NUM_BITS;
    t1 = NUM_BITS - 1;
    t2 = 0;
    t3 = 0;
    case (NUM_BITS)
      3:  begin t0 = 3;  t1 = 2;  end
      4:  begin t0 = 4;  t1 = 3;  end
      5:  begin t0 = 5;  t1 = 3;  end
      6:  begin t0 = 6;  t1 = 5;  end
      7:  begin t0 = 7;  t1 = 6;  end
      8:  begin t0 = 8;  t1 = 6;  t2 = 5;  t3 = 4; end
      9:  begin t0 = 9;  t1 = 5;  end
      10: begin t0 = 10; t1 = 7;  end
      11: begin t0 = 11; t1 = 9;  end
      12: begin t0 = 12; t1 = 6;  t2 = 4;  t3 = 1; end
      13: begin t0 = 13; t1 = 4;  t2 = 3;  t3 = 1; end
      14: begin t0 = 14; t1 = 5;  t2 = 3;  t3 = 1; end
      15: begin t0 = 15; t1 = 14; end
      16: begin t0 = 16; t1 = 15; t2 = 13; t3 = 4; end
      default: begin t0 = NUM_BITS; t1 = NUM_BITS - 1; end
    endcase
    for (int i = 1; i <= NUM_BITS; i++)
      m[i] = (i == t0) || (i == t1) || (i == t2) || (i == t3);
    return m;
  endfunction

  localparam logic [NUM_BITS:1] TAPS = tap_mask();

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} state_t;

  state_t            state;
  logic [NUM_BITS:1] c;
  logic [FW-1:0]     fill_cnt;
  logic [MW-1:0]     match_cnt;
  logic [BW-1:0]     bad_cnt;

  logic p;
  logic miss;
  logic all_ones;

  // Every table entry has an even tap count, so the XNOR chain is the
  // inverted parity of the tapped bits.
  assign p        = ~^(c & TAPS);
  assign miss     = bus.bit_in ^ p;
  assign all_ones = &c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEED;
      c             <= C_RST;
      fill_cnt      <= '0;
      match_cnt     <= '0;
      bad_cnt       <= '0;
      bus.locked    <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.err_pulse <= 1'b0;
      if (bus.restart) begin
        state      <= SEED;
        fill_cnt   <= '0;
        match_cnt  <= '0;
        bad_cnt    <= '0;
        bus.locked <= 1'b0;
      end else if (bus.bit_valid) begin
        case (state)
          SEED: begin
            c <= {c[NUM_BITS-1:1], bus.bit_in};
            if (fill_cnt == FILL_LAST) begin
              state     <= HUNT;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          HUNT: begin
            c <= {c[NUM_BITS-1:1], bus.bit_in};
            // All-ones is the XNOR lockup state: a stuck-high line would
            // otherwise predict itself forever and look locked.
            if (all_ones || miss) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              state      <= LOCKED;
              match_cnt  <= '0;
              bad_cnt    <= '0;
              bus.locked <= 1'b1;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so a flipped bit cannot poison
            // the following predictions.
            c <= {c[NUM_BITS-1:1], p};
            if (miss) begin
              bus.err_pulse <= 1'b1;
              if (~&bus.err_count)
                bus.err_count <= bus.err_count + 1'b1;
              if (bad_cnt == BAD_LAST) begin
                state      <= SEED;
                fill_cnt   <= '0;
                bad_cnt    <= '0;
                bus.locked <= 1'b0;
              end else begin
                bad_cnt <= bad_cnt + 1'b1;
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= SEED;
        endcase
      end
      // Clear wins over an increment from the same cycle's error.
      if (bus.err_clear)
        bus.err_count <= '0;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  prbs_checker_if #(.ERR_WIDTH(8)) bus ();

  prbs_checker #(
    .NUM_BITS(8),
    .LOCK_COUNT(16),
    .UNLOCK_ERRS(4),
    .ERR_WIDTH(8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic       lk;
    logic       pl;
    logic [7:0] cnt;
  } sb_item_t;

  sb_item_t   sb[$];
  logic [7:0] e_cnt = 8'd0;
  logic [7:0] g = 8'h5A;

  // Reference generator: 8-bit XNOR Fibonacci, taps 8,6,5,4, feedback into bit 1.
  function automatic logic gen_next();
    logic f;
    f = ~(g[7] ^ g[5] ^ g[4] ^ g[3]);
    g = {g[6:0], f};
    return f;
  endfunction

  // Scoreboard: every driven cycle's expected outputs are compared one cycle later.
  always @(negedge clk) begin
    sb_item_t it;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      checks++;
      if (bus.locked !== it.lk || bus.err_pulse !== it.pl || bus.err_count !== it.cnt) begin
        errors++;
        $display("FAIL stream cyc=%0d locked got %b want %b, err_pulse got %b want %b, err_count got %0d want %0d",
                 cyc, bus.locked, it.lk, bus.err_pulse, it.pl, bus.err_count, it.cnt);
      end
    end
  end

  task automatic send(input logic b, input logic v, input logic rs, input logic ec,
                      input logic xl, input logic xp);
    sb_item_t it;
    @(negedge clk);
    bus.bit_in    = b;
    bus.bit_valid = v;
    bus.restart   = rs;
    bus.err_clear = ec;
    if (ec) e_cnt = 8'd0;
    else if (xp && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    it.due = cyc + 1;
    it.lk  = xl;
    it.pl  = xp;
    it.cnt = e_cnt;
    sb.push_back(it);
  endtask

  task automatic idle(input logic xl);
    send(1'b0, 1'b0, 1'b0, 1'b0, xl, 1'b0);
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.restart   = 1'b0;
    bus.err_clear = 1'b0;
    sb.delete();
    e_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b1;
    bus.restart   = 1'b0;
    bus.err_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.bit_in = ~bus.bit_in;
    end
    #1;
    checks++;
    if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got locked=%b pulse=%b count=%0d want 0 0 0",
               bus.locked, bus.err_pulse, bus.err_count);
    end
    bus.bit_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  task automatic test_clean();
    logic b;
    for (int n = 1; n <= 1000; n++) begin
      b = gen_next();
      send(b, 1'b1, 1'b0, 1'b0, n >= 24, 1'b0);
    end
    idle(1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL clean_1000 got locked=%b count=%0d want 1 0", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_single_flip();
    logic b, f;
    for (int k = 1; k <= 250; k++) begin
      b = gen_next();
      f = (k == 50);
      send(b ^ f, 1'b1, 1'b0, 1'b0, 1'b1, f);
    end
    idle(1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL single_flip got locked=%b count=%0d want 1 1", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_burst();
    logic b, f;
    for (int k = 1; k <= 120; k++) begin
      b = gen_next();
      f = (k >= 60 && k <= 63);
      send(b ^ f, 1'b1, 1'b0, 1'b0, (k <= 62) || (k >= 87), f);
    end
    idle(1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd5) begin
      errors++;
      $display("FAIL burst_relock got locked=%b count=%0d want 1 5", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_lockup();
    apply_reset();
    for (int k = 1; k <= 200; k++)
      send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    checks++;
    if (bus.locked !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL lockup got locked=%b count=%0d want 0 0", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_gaps_saturation();
    logic b, f, rb;
    int   nq;
    apply_reset();
    nq = 0;
    for (int it = 0; it < 2000 && nq < 40; it++) begin
      if ($urandom_range(0, 99) < 30) begin
        nq++;
        b = gen_next();
        send(b, 1'b1, 1'b0, 1'b0, nq >= 24, 1'b0);
      end else begin
        rb = 1'($urandom_range(0, 1));
        send(rb, 1'b0, 1'b0, 1'b0, nq >= 24, 1'b0);
      end
    end
    idle(nq >= 24);
    checks++;
    if (nq < 40 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL gapped_lock got locked=%b qualified=%0d want 1 40", bus.locked, nq);
    end
    for (int k = 1; k <= 3000; k++) begin
      b = gen_next();
      f = (k % 10 == 0);
      send(b ^ f, 1'b1, 1'b0, 1'b0, 1'b1, f);
    end
    idle(1'b1);
    checks++;
    if (bus.err_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate got count=%0d want 255", bus.err_count);
    end
    b = gen_next();
    send(~b, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    checks++;
    if (bus.err_count !== 8'd0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL err_clear got count=%0d locked=%b want 0 1", bus.err_count, bus.locked);
    end
  endtask

  task automatic test_precedence();
    logic b;
    for (int k = 1; k <= 4; k++) begin
      b = gen_next();
      send(b ^ (k == 1), 1'b1, 1'b0, 1'b0, 1'b1, k == 1);
    end
    send(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 30; n++) begin
      b = gen_next();
      send(b, 1'b1, 1'b0, 1'b0, n >= 24, 1'b0);
    end
    idle(1'b1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL restart_relock got locked=%b count=%0d want 1 1", bus.locked, bus.err_count);
    end
    b = gen_next();
    send(~b, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    checks++;
    if (bus.locked !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL restart_and_clear got locked=%b count=%0d want 0 0", bus.locked, bus.err_count);
    end
    for (int n = 1; n <= 24; n++) begin
      b = gen_next();
      send(b, 1'b1, 1'b0, 1'b0, n >= 24, 1'b0);
    end
    b = gen_next();
    send(~b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (bus.locked !== 1'b1 || bus.err_pulse !== 1'b1 || bus.err_count !== 8'd1) begin
      errors++;
      $display("FAIL pre_async_reset got locked=%b pulse=%b count=%0d want 1 1 1",
               bus.locked, bus.err_pulse, bus.err_count);
    end
    rst_n = 1'b0;
    sb.delete();
    e_cnt = 8'd0;
    bus.bit_valid = 1'b0;
    #1;
    checks++;
    if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got locked=%b pulse=%b count=%0d want 0 0 0",
               bus.locked, bus.err_pulse, bus.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_flip();
    test_burst();
    test_lockup();
    test_gaps_saturation();
    test_precedence();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random sequence checker paired with the on-chip `lfsr` generator. It consumes the generator's feedback bit stream one bit per qualified cycle and self-synchronises to it. It then reports lock status and bit errors. It sits at the receive end of the loopback/self-test path and uses the same XNOR Fibonacci polynomials and bit ordering as `lfsr`.

## Interface
- `NUM_BITS`, default 8: LFSR length; legal 3–16; same polynomial table as `lfsr`.
- `LOCK_COUNT`, default 16: consecutive matches required to declare lock; ≥1.
- `UNLOCK_ERRS`, default 4: consecutive mismatches while locked that force re-acquisition; ≥1.
- `ERR_WIDTH`, default 8: width of the error counter.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `bit_in`  input  1  received sequence bit; sampled only when `bit_valid`=1.
- `bit_valid`  input  1  qualifies `bit_in`; when low, all state holds.
- `restart`  input  1  synchronous; forces re-acquisition.
- `err_clear`  input  1  synchronous; zeroes `err_count`.
- `locked`  output  1  registered; 1 while in LOCKED.
- `err_pulse`  output  1  registered; one-cycle pulse per counted error.
- `err_count`  output  ERR_WIDTH  registered, saturating count of errors seen while locked.

## Operation
- Shadow register `c[NUM_BITS:1]` holds the checker's copy of the generator state. The predicted bit `p` is the XNOR of the polynomial taps of `c`, identical to `lfsr` (for 8 bits: c[8]^~c[6]^~c[5]^~c[4]).
- Each qualified bit shifts the register: `c <= {c[NUM_BITS-1:1], d}`. The loaded bit `d` depends on state, as given below.
- SEED (reset state):
  - `d = bit_in`. The fill counter increments on each qualified bit.
  - After NUM_BITS qualified bits, go to HUNT with the match-run counter at 0.
- HUNT:
  - `d = bit_in`, so the checker self-synchronises.
  - If `bit_in == p`, the match run increments. Otherwise the match run goes to 0; no error is counted.
  - If `c` is all-ones before the shift, the match run is held at 0. This is the XNOR lockup state, so a constant-1 stream never locks.
  - When the match run reaches LOCK_COUNT, go to LOCKED and clear the bad-run counter.
- LOCKED:
  - `d = p`, so an isolated flipped bit does not corrupt later predictions.
  - On mismatch: `err_count` increments (saturating at all-ones), `err_pulse` is 1 on the next cycle, and the bad run increments.
  - On match: the bad run clears.
  - When the bad run reaches UNLOCK_ERRS, go to SEED. `locked` drops and the fill counter clears. The UNLOCK_ERRS-th mismatch is still counted.
- `restart`=1 goes to SEED and clears the fill, match and bad-run counters, regardless of `bit_valid`. `restart` has priority over any bit processing in that cycle. It does not clear `err_count` or `c`.
- `err_clear`=1 sets `err_count` to 0 next cycle, even if the same cycle's bit is an error. `err_pulse` still fires for that error.
- `restart` and `err_clear` may both be asserted in the same cycle; both take effect.

## Timing
- Reset values:
  - State SEED; `c` = {NUM_BITS/2{2'b01}}; all counters 0.
  - `locked`=0, `err_pulse`=0, `err_count`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `locked` rises in the cycle after the LOCK_COUNT-th consecutive matching bit is sampled.
- With an error-free stream and no gaps, the minimum lock latency is NUM_BITS+LOCK_COUNT qualified bits.
- `err_pulse` and the `err_count` update are visible in the cycle after the erroneous bit is sampled. Back-to-back errors give back-to-back pulses.
- `locked` falls in the cycle after the UNLOCK_ERRS-th consecutive mismatch is sampled, coincident with that error's `err_pulse`.
- `bit_valid` gaps of any length do not affect counters or lock; processing resumes on the next qualified bit.
- Asserting `rst_n` low mid-operation returns everything to reset values immediately.

## Test plan
- **Clean acquisition.** `lfsr` (NUM_BITS=8) enabled, feedback bit driven to `bit_in` with `bit_valid`=1 every cycle → `locked`=1 in the cycle after the 24th bit. `err_count` stays 0 over 1000 bits.
- **Single flip while locked.** Invert bit 50 → exactly one `err_pulse` on the following cycle; `err_count`=1; `locked` stays 1. No further errors over the next 200 bits.
- **Burst unlock and relock.**
  - Invert bits 60–63 → four pulses, `err_count`=4, `locked` falls after bit 63.
  - Clean stream afterwards → `locked` rises again 24 bits later.
- **Lockup stream.** Constant `bit_in`=1 for 200 bits → `locked` never asserts; `err_count`=0.
- **Gaps and saturation.**
  - Randomised `bit_valid` duty of about 30% → lock after 24 qualified bits.
  - Then inject 300 isolated flips spaced 10 bits apart → `err_count` saturates at 255.
  - Then `err_clear` → `err_count`=0.
- **Control precedence.**
  - `restart` while locked → `locked`=0 next cycle; relock after 24 bits; `err_count` is preserved.
  - `restart` and `err_clear` in the same cycle → both take effect.
  - `rst_n` pulsed low mid-stream → all outputs return to 0 asynchronously.
